// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter_pkg
//  Description : Shared definitions for the BRAM port arbiter: the clogb2
//                width helper and the read-tag pipeline stage type.
//  Contents    : clogb2()   - bits needed to hold values 0..depth
//                tag_t      - {valid, requester id} carried with each read
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

    // Number of bits needed to represent the value 'depth'
    // (clogb2(N-1) is the index width for N entries).
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        for (r = 0; d > 0; r++) begin
            d = d >> 1;
        end
        return r;
    endfunction

    // The requester count is bounded at 8, so the tag id is sized for the
    // largest configuration and narrower builds leave the top bits at zero.
    localparam int c_MAX_REQ = 8;
    localparam int c_ID_W    = clogb2(c_MAX_REQ - 1);

    typedef struct packed {
        logic              valid;
        logic [c_ID_W-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin grant generator. The search for a valid
//                requester starts at a rotating pointer; after an accepted
//                grant the pointer moves to the slot just past the winner.
//  Ports       : clock   - rising-edge clock
//                reset   - synchronous active-high reset (pointer -> 0)
//                req     - per-requester request lines
//                advance - a grant was accepted this cycle
//                grant   - one-hot (or zero) grant, combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int c_PW = clogb2(NUM_REQ - 1);

    logic [c_PW-1:0] r_ptr;
    logic [c_PW-1:0] w_idx;
    logic [c_PW-1:0] w_win;
    logic            w_found;

    // Scan the requesters in rotated order starting at r_ptr; first hit wins.
    always_comb begin
        grant   = '0;
        w_win   = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_win        = w_idx;
                w_found      = 1'b1;
            end
        end
        // No grants while reset is held, so nothing is accepted mid-reset.
        if (reset) begin
            grant = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            if (int'(w_win) == NUM_REQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_win + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter
//  Description : Shares one BRAM port among NUM_REQ requesters. A round-robin
//                arbiter picks one valid requester per cycle, its request is
//                steered onto the BRAM port, and reads carry a tag through a
//                two-stage pipeline that matches the BRAM's two-cycle
//                registered read latency so the data returns to the right
//                requester.
//  Ports       : clock, reset                  - clock / sync active-high reset
//                req_valid/ready/write         - per-requester handshake
//                req_addr/wdata/wmask          - packed per-requester slices
//                resp_valid, resp_data         - read response (no backpressure)
//                bram_en/we/addr/din           - BRAM port controls
//                bram_regce, bram_reset        - BRAM output register control
//                bram_dout                     - BRAM registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter  int RAM_WIDTH  = 32,
    parameter  int RAM_DEPTH  = 1024,
    parameter  int BYTE_WIDTH = 8,
    parameter  int NUM_REQ    = 2,
    localparam int c_AW       = clogb2(RAM_DEPTH - 1),
    localparam int c_NB       = RAM_WIDTH / BYTE_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*c_AW-1:0]      req_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*c_NB-1:0]      req_wmask,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [RAM_WIDTH-1:0]         resp_data,
    output logic                         bram_en,
    output logic [c_NB-1:0]              bram_we,
    output logic [c_AW-1:0]              bram_addr,
    output logic [RAM_WIDTH-1:0]         bram_din,
    output logic                         bram_regce,
    output logic                         bram_reset,
    input  logic [RAM_WIDTH-1:0]         bram_dout
);

    localparam int c_IW = clogb2(NUM_REQ - 1);

    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept;
    logic [c_IW-1:0]    w_win;
    logic               w_is_write;
    tag_t               w_tag0;
    tag_t               r_tag1;
    tag_t               r_tag2;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_accept),
        .grant   (w_grant)
    );

    // Grant is already gated by valid, so any grant bit is an acceptance.
    assign w_accept  = |w_grant;
    assign req_ready = w_grant;

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win = c_IW'(i);
            end
        end
    end

    assign w_is_write = req_write[w_win];

    assign bram_en   = w_accept;
    assign bram_addr = req_addr[int'(w_win)*c_AW +: c_AW];
    assign bram_din  = req_wdata[int'(w_win)*RAM_WIDTH +: RAM_WIDTH];
    assign bram_we   = (w_accept && w_is_write) ? req_wmask[int'(w_win)*c_NB +: c_NB] : '0;

    // Only reads enter the tag pipeline; writes never generate a response.
    always_comb begin
        w_tag0       = '0;
        w_tag0.valid = w_accept && !w_is_write;
        w_tag0.id    = c_ID_W'(w_win);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag1 <= w_tag0;
            r_tag2 <= r_tag1;
        end
    end

    // Stage 1 valid means the BRAM latch holds read data that must be moved
    // into the output register this cycle.
    assign bram_regce = r_tag1.valid && !reset;
    assign bram_reset = reset;
    assign resp_data  = bram_dout;

    // Reset also masks the response directly so a read already in stage 2
    // when reset rises cannot strobe.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = r_tag2.valid && !reset && (r_tag2.id == c_ID_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_port_arbiter
//  Description : Self-checking bench for bram_port_arbiter with a behavioural
//                BRAM (two-cycle registered read), a reference model of the
//                arbitration/memory/response rules, directed scenarios with
//                literal expectations, then randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int NB = 4;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*W-1:0]    req_wdata;
    logic [N*NB-1:0]   req_wmask;
    logic [N-1:0]      resp_valid;
    logic [W-1:0]      resp_data;
    logic              bram_en;
    logic [NB-1:0]     bram_we;
    logic [AW-1:0]     bram_addr;
    logic [W-1:0]      bram_din;
    logic              bram_regce;
    logic              bram_reset;
    logic [W-1:0]      bram_dout;

    int n_checks = 0;
    int n_pass   = 0;

    bram_port_arbiter #(
        .RAM_WIDTH  (W),
        .RAM_DEPTH  (D),
        .BYTE_WIDTH (8),
        .NUM_REQ    (N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_regce (bram_regce),
        .bram_reset (bram_reset),
        .bram_dout  (bram_dout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [W-1:0] init_word(input int a);
        return (32'(a) * 32'h0101_0101) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- behavioural BRAM (read-first, registered output) ------
    logic [W-1:0] mem [D];
    logic [W-1:0] latch_q;
    initial begin
        for (int a = 0; a < D; a++) mem[a] = init_word(a);
        latch_q   = '0;
        bram_dout = '0;
        forever begin
            @(posedge clock);
            if (bram_en) begin
                latch_q <= mem[bram_addr];
                for (int b = 0; b < NB; b++)
                    if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
            end
            if (bram_reset)      bram_dout <= '0;
            else if (bram_regce) bram_dout <= latch_q;
        end
    end

    // ---------------- reference model + per-cycle compare -------------------
    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] data;
    } rsp_t;

    initial begin
        logic [W-1:0] ref_mem [D];
        rsp_t         q[$];
        int           p;
        int           cyc;
        int           win;
        bit           prev_rd;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_rv;
        logic [NB-1:0] exp_we;
        logic [W-1:0] exp_data;
        logic [AW-1:0] w_a;
        logic [W-1:0]  w_d;
        logic [NB-1:0] w_m;
        for (int a = 0; a < D; a++) ref_mem[a] = init_word(a);
        p = 0; cyc = 0; prev_rd = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            win = -1;
            exp_grant = '0;
            if (!reset) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(p + k) % N]) win = (p + k) % N;
                end
            end
            if (win >= 0) exp_grant[win] = 1'b1;
            w_a = (win >= 0) ? req_addr[win*AW +: AW] : '0;
            w_d = (win >= 0) ? req_wdata[win*W +: W]  : '0;
            w_m = (win >= 0) ? req_wmask[win*NB +: NB] : '0;
            exp_we = (win >= 0 && req_write[win]) ? w_m : '0;

            chk("req_ready",  32'(req_ready),  32'(exp_grant));
            chk("bram_en",    32'(bram_en),    32'(win >= 0));
            chk("bram_we",    32'(bram_we),    32'(exp_we));
            chk("bram_regce", 32'(bram_regce), 32'(!reset && prev_rd));
            chk("bram_reset", 32'(bram_reset), 32'(reset));
            if (win >= 0) begin
                chk("bram_addr", 32'(bram_addr), 32'(w_a));
                chk("bram_din",  bram_din, w_d);
            end

            exp_rv = '0;
            exp_data = '0;
            if (!reset && q.size() > 0 && q[0].due == cyc) begin
                exp_rv[q[0].id] = 1'b1;
                exp_data = q[0].data;
                void'(q.pop_front());
            end
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv != '0) chk("resp_data", resp_data, exp_data);
            chk("resp_passthru", resp_data, bram_dout);

            if (reset) begin
                p = 0;
                q.delete();
                prev_rd = 1'b0;
            end else begin
                prev_rd = 1'b0;
                if (win >= 0) begin
                    p = (win + 1) % N;
                    if (req_write[win]) begin
                        for (int b = 0; b < NB; b++)
                            if (w_m[b]) ref_mem[w_a][b*8 +: 8] = w_d[b*8 +: 8];
                    end else begin
                        q.push_back('{due: cyc + 2, id: win, data: ref_mem[w_a]});
                        prev_rd = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic idle();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
    endtask

    task automatic set_req(input int i, input bit wr, input int a,
                           input logic [W-1:0] d, input logic [NB-1:0] m);
        req_valid[i]             = 1'b1;
        req_write[i]             = wr;
        req_addr[i*AW +: AW]     = AW'(a);
        req_wdata[i*W +: W]      = d;
        req_wmask[i*NB +: NB]    = m;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) adv();
        @(negedge clock);
        chk("rst_ready",      32'(req_ready),  32'h0);
        chk("rst_bram_reset", 32'(bram_reset), 32'h1);

        // first cycle after reset: preload writes through the port
        adv(); reset = 1'b0; set_req(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF);
        @(negedge clock); chk("first_grant", 32'(req_ready), 32'h1);
        adv(); idle(); set_req(1, 1'b1, 3, 32'hAAAA_AAAA, 4'hF);
        adv(); idle(); set_req(1, 1'b1, 7, 32'h0, 4'hF);     // p now 2 -> 2 scans to 1

        // single read by requester 1 of addr 5
        adv(); idle(); set_req(1, 1'b0, 5, 32'h0, 4'h0);
        @(negedge clock); chk("single_rd_grant", 32'(req_ready), 32'h2);
        adv(); idle();
        @(negedge clock); chk("single_rd_early", 32'(resp_valid), 32'h0);
        @(negedge clock);
        chk("single_rd_valid", 32'(resp_valid), 32'h2);
        chk("single_rd_data",  resp_data, 32'hDEAD_BEEF);

        // requester 2 moves the pointer back to 0
        adv(); idle(); set_req(2, 1'b0, 0, 32'h0, 4'h0);

        // contention: 0 and 1 held valid for six cycles
        adv(); idle();
        set_req(0, 1'b0, 8, 32'h0, 4'h0);
        set_req(1, 1'b0, 9, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("contend_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            adv();
        end
        idle();

        // byte write then read
        set_req(0, 1'b1, 3, 32'h1122_3344, 4'b0101);
        adv(); idle(); set_req(0, 1'b0, 3, 32'h0, 4'h0);
        @(negedge clock); chk("bytewr_rd_grant", 32'(req_ready), 32'h1);
        adv(); idle();
        @(negedge clock);
        @(negedge clock);
        chk("bytewr_valid", 32'(resp_valid), 32'h1);
        chk("bytewr_data",  resp_data, 32'hAA22_AA44);

        // write at T, read same address at T+1
        adv(); idle(); set_req(0, 1'b1, 7, 32'h5, 4'hF);
        adv(); idle(); set_req(1, 1'b0, 7, 32'h0, 4'h0);
        adv(); idle();
        @(negedge clock);
        @(negedge clock);
        chk("wr_rd_valid", 32'(resp_valid), 32'h2);
        chk("wr_rd_data",  resp_data, 32'h5);

        // read at T, write from other port at T+1 -> old data
        adv(); idle(); set_req(1, 1'b0, 7, 32'h0, 4'h0);
        adv(); idle(); set_req(0, 1'b1, 7, 32'h99, 4'hF);
        adv(); idle();
        @(negedge clock);
        chk("rd_wr_valid", 32'(resp_valid), 32'h2);
        chk("rd_wr_data",  resp_data, 32'h5);

        // reset while a read is in flight
        adv(); idle(); set_req(0, 1'b0, 5, 32'h0, 4'h0);
        adv(); idle(); reset = 1'b1;
        adv(); reset = 1'b0;
        set_req(0, 1'b0, 1, 32'h0, 4'h0);
        set_req(1, 1'b0, 2, 32'h0, 4'h0);
        set_req(2, 1'b0, 3, 32'h0, 4'h0);
        @(negedge clock);
        chk("rst_flight_noresp", 32'(resp_valid), 32'h0);
        chk("post_rst_grant",    32'(req_ready),  32'h1);

        // idle keeps pointer (now 1)
        adv(); idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clock); chk("idle_en", 32'(bram_en), 32'h0);
            adv();
        end
        set_req(0, 1'b0, 1, 32'h0, 4'h0);
        set_req(1, 1'b0, 2, 32'h0, 4'h0);
        set_req(2, 1'b0, 3, 32'h0, 4'h0);
        @(negedge clock); chk("idle_ptr_kept", 32'(req_ready), 32'h2);

        // zero-mask write leaves memory unchanged
        adv(); idle(); set_req(0, 1'b1, 5, 32'hFFFF_FFFF, 4'h0);
        adv(); idle(); set_req(0, 1'b0, 5, 32'h0, 4'h0);
        adv(); idle();
        @(negedge clock);
        @(negedge clock);
        chk("zmask_valid", 32'(resp_valid), 32'h1);
        chk("zmask_data",  resp_data, 32'hDEAD_BEEF);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            adv();
            idle();
            reset = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                            $urandom, 4'($urandom_range(0, 15)));
            end
        end
        adv(); idle(); reset = 1'b0;
        repeat (4) adv();
        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
